// File: rtl/imem_serial_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_serial_loader_pkg
// Shared definitions for the byte-stream IMEM programmer: FSM state
// encoding, frame start marker, instruction memory geometry and the
// address bit that selects between the low and high instruction banks.
// ----------------------------------------------------------------------------
package imem_serial_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CNT  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_WR   = 3'd4,
        ST_CHK  = 3'd5,
        ST_DONE = 3'd6,
        ST_ERR  = 3'd7
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_VAL = 8'hA5;
    localparam int         IMEM_DEPTH    = 32;
    localparam int         IMEM_WORD_W   = 16;
    // addr[BANK_BIT] picks the bank, addr[BANK_BIT-1:0] is the word index
    localparam int         BANK_BIT      = 4;

endpackage

// File: rtl/imem_serial_loader.sv
// ----------------------------------------------------------------------------
// imem_serial_loader
// Receives a framed byte stream (SYNC, COUNT, COUNT x {hi, lo}, XOR checksum)
// and writes the words into two 16-word instruction banks. The CPU is held
// in reset from the moment a sync byte is accepted until the frame finishes.
//
// Ports
//   CLOCK             in   system clock, rising edge
//   RESET             in   asynchronous active-high reset
//   BYTE_IN[7:0]      in   incoming byte
//   BYTE_VALID        in   BYTE_IN valid (transfer on BYTE_VALID & BYTE_READY)
//   BYTE_READY        out  loader accepts a byte this cycle (low only in WR)
//   IMEM_INPUT[15:0]  out  word to write, shared by both banks
//   WRITE_SELECT[3:0] out  word index within the selected bank
//   WRITE_ENABLE_LOW  out  one-cycle write strobe for addresses 0-15
//   WRITE_ENABLE_HIGH out  one-cycle write strobe for addresses 16-31
//   CPU_HOLD          out  high while a frame is being loaded
//   DONE              out  sticky: last frame loaded with good checksum
//   ERROR             out  sticky: last frame rejected (count or checksum)
// ----------------------------------------------------------------------------
module imem_serial_loader
    import imem_serial_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_VAL,
    parameter int         DEPTH     = IMEM_DEPTH,
    parameter int         WORD_W    = IMEM_WORD_W
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic [WORD_W-1:0] IMEM_INPUT,
    output logic [3:0]        WRITE_SELECT,
    output logic              WRITE_ENABLE_LOW,
    output logic              WRITE_ENABLE_HIGH,
    output logic              CPU_HOLD,
    output logic              DONE,
    output logic              ERROR
);

    localparam int         ADDR_W  = $clog2(DEPTH);
    localparam int         REM_W   = $clog2(DEPTH + 1);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    loader_state_t     r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [REM_W-1:0]  r_remaining;
    logic [7:0]        r_chk;
    logic [7:0]        r_hi;
    logic [WORD_W-1:0] r_imem_input;
    logic [3:0]        r_write_select;
    logic              r_we_low;
    logic              r_we_high;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_error;

    logic w_ready;
    logic w_accept;

    // Only the write cycle refuses bytes; everything else is a byte state.
    assign w_ready  = (r_state != ST_WR);
    assign w_accept = BYTE_VALID & w_ready;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_chk          <= '0;
            r_hi           <= '0;
            r_imem_input   <= '0;
            r_write_select <= '0;
            r_we_low       <= 1'b0;
            r_we_high      <= 1'b0;
            r_cpu_hold     <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            // Strobes are single-cycle: set on the lo-byte accept so they are
            // high exactly during the WR cycle, then dropped here.
            r_we_low  <= 1'b0;
            r_we_high <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_accept && BYTE_IN == SYNC_BYTE) begin
                        r_state    <= ST_CNT;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_addr     <= '0;
                        r_chk      <= '0;
                    end
                end
                ST_CNT: begin
                    if (w_accept) begin
                        if (BYTE_IN == 8'd0 || BYTE_IN > DEPTH_B) begin
                            r_state    <= ST_ERR;
                            r_error    <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_remaining <= BYTE_IN[REM_W-1:0];
                            r_state     <= ST_HI;
                        end
                    end
                end
                ST_HI: begin
                    if (w_accept) begin
                        r_hi    <= BYTE_IN;
                        r_chk   <= r_chk ^ BYTE_IN;
                        r_state <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (w_accept) begin
                        r_chk          <= r_chk ^ BYTE_IN;
                        r_imem_input   <= {r_hi, BYTE_IN};
                        r_write_select <= r_addr[BANK_BIT-1:0];
                        r_we_low       <= ~r_addr[BANK_BIT];
                        r_we_high      <= r_addr[BANK_BIT];
                        r_state        <= ST_WR;
                    end
                end
                ST_WR: begin
                    r_addr      <= r_addr + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                    r_state     <= (r_remaining == REM_W'(1)) ? ST_CHK : ST_HI;
                end
                ST_CHK: begin
                    if (w_accept) begin
                        r_cpu_hold <= 1'b0;
                        if (BYTE_IN == r_chk) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_ERR;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign BYTE_READY        = w_ready;
    assign IMEM_INPUT        = r_imem_input;
    assign WRITE_SELECT      = r_write_select;
    assign WRITE_ENABLE_LOW  = r_we_low;
    assign WRITE_ENABLE_HIGH = r_we_high;
    assign CPU_HOLD          = r_cpu_hold;
    assign DONE              = r_done;
    assign ERROR             = r_error;

endmodule

// File: tb/tb_imem_serial_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_serial_loader
// Directed bench for imem_serial_loader. A negedge monitor mirrors the two
// instruction banks from the write strobes; frames are built from an image
// table with the checksum computed here.
// ----------------------------------------------------------------------------
module tb_imem_serial_loader;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  BYTE_IN = 8'h00;
    logic        BYTE_VALID = 1'b0;
    logic        BYTE_READY;
    logic [15:0] IMEM_INPUT;
    logic [3:0]  WRITE_SELECT;
    logic        WRITE_ENABLE_LOW;
    logic        WRITE_ENABLE_HIGH;
    logic        CPU_HOLD;
    logic        DONE;
    logic        ERROR;

    imem_serial_loader dut (
        .CLOCK            (CLOCK),
        .RESET            (RESET),
        .BYTE_IN          (BYTE_IN),
        .BYTE_VALID       (BYTE_VALID),
        .BYTE_READY       (BYTE_READY),
        .IMEM_INPUT       (IMEM_INPUT),
        .WRITE_SELECT     (WRITE_SELECT),
        .WRITE_ENABLE_LOW (WRITE_ENABLE_LOW),
        .WRITE_ENABLE_HIGH(WRITE_ENABLE_HIGH),
        .CPU_HOLD         (CPU_HOLD),
        .DONE             (DONE),
        .ERROR            (ERROR)
    );

    always #5 CLOCK = ~CLOCK;

    int n_err = 0;
    int n_chk = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- bank model / monitor ----------------
    logic [15:0] mem_lo [0:15];
    logic [15:0] mem_hi [0:15];
    logic [4:0]  wlog [$];
    int          wr_cnt  = 0;
    int          viol    = 0;
    int          rdy_low = 0;
    int          cyc     = 0;

    always @(posedge CLOCK) cyc++;

    always @(negedge CLOCK) begin
        if (!RESET) begin
            if (WRITE_ENABLE_LOW) begin
                mem_lo[WRITE_SELECT] = IMEM_INPUT;
                wlog.push_back({1'b0, WRITE_SELECT});
                wr_cnt++;
            end
            if (WRITE_ENABLE_HIGH) begin
                mem_hi[WRITE_SELECT] = IMEM_INPUT;
                wlog.push_back({1'b1, WRITE_SELECT});
                wr_cnt++;
            end
            if (WRITE_ENABLE_LOW && WRITE_ENABLE_HIGH) viol++;
            // ready must be low exactly in the write cycle
            if (BYTE_READY == (WRITE_ENABLE_LOW | WRITE_ENABLE_HIGH)) viol++;
            if (!BYTE_READY) rdy_low++;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [15:0] img [0:31];
    int          gap_max = 0;

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            mem_lo[i] = 16'h0000;
            mem_hi[i] = 16'h0000;
        end
        wlog.delete();
        wr_cnt = 0;
    endtask

    task automatic idle(input int n);
        BYTE_VALID = 1'b0;
        repeat (n) @(negedge CLOCK);
        #1;
    endtask

    // Called away from the posedge; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        BYTE_IN    = b;
        BYTE_VALID = 1'b1;
        while (!BYTE_READY && guard < 8) begin
            @(negedge CLOCK);
            guard++;
        end
        if (guard >= 8) check_val("ready_timeout", 32'(BYTE_READY), 32'd1);
        @(posedge CLOCK);
        @(negedge CLOCK);
        if (gap_max > 0) begin
            BYTE_VALID = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge CLOCK);
        end
    endtask

    function automatic logic [7:0] img_chk(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) c = c ^ img[i][15:8] ^ img[i][7:0];
        return c;
    endfunction

    task automatic send_frame(input int n, input logic [7:0] flip);
        send_byte(8'hA5);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            send_byte(img[i][15:8]);
            send_byte(img[i][7:0]);
        end
        send_byte(img_chk(n) ^ flip);
        $display("frame n=%0d flip=%02h done=%0b error=%0b writes=%0d", n, flip, DONE, ERROR, wr_cnt);
    endtask

    task automatic check_image(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < 16) check_val(tag, 32'(mem_lo[i]), 32'(img[i]));
            else        check_val(tag, 32'(mem_hi[i-16]), 32'(img[i]));
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) img[i] = 16'($urandom);
    endtask

    // ---------------- tests ----------------
    int c0, r0;

    initial begin
        clear_model();
        repeat (3) @(negedge CLOCK);
        // reset state
        check_val("rst_ready", 32'(BYTE_READY), 32'd1);
        check_val("rst_data",  32'(IMEM_INPUT), 32'd0);
        check_val("rst_sel",   32'(WRITE_SELECT), 32'd0);
        check_val("rst_we",    32'({WRITE_ENABLE_HIGH, WRITE_ENABLE_LOW}), 32'd0);
        check_val("rst_flags", 32'({CPU_HOLD, DONE, ERROR}), 32'd0);
        RESET = 1'b0;
        idle(2);

        // 1: two-word frame, hand-computed checksum 0x08
        $display("test1 two-word frame");
        send_byte(8'hA5);
        check_val("t1_hold_on", 32'(CPU_HOLD), 32'd1);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        // strobe is the cycle right after the lo byte
        check_val("t1_we0",   32'({WRITE_ENABLE_HIGH, WRITE_ENABLE_LOW, BYTE_READY}), 32'b010);
        check_val("t1_data0", 32'(IMEM_INPUT), 32'h1234);
        check_val("t1_sel0",  32'(WRITE_SELECT), 32'd0);
        send_byte(8'h56);
        send_byte(8'h78);
        check_val("t1_data1", 32'(IMEM_INPUT), 32'h5678);
        check_val("t1_sel1",  32'(WRITE_SELECT), 32'd1);
        send_byte(8'h08);
        idle(2);
        check_val("t1_flags", 32'({CPU_HOLD, DONE, ERROR}), 32'b010);
        check_val("t1_wrs",   32'(wr_cnt), 32'd2);
        check_val("t1_mem0",  32'(mem_lo[0]), 32'h1234);
        check_val("t1_mem1",  32'(mem_lo[1]), 32'h5678);
        // non-sync byte in DONE is dropped, DONE stays
        send_byte(8'h11);
        idle(2);
        check_val("t1_sticky", 32'({CPU_HOLD, DONE, ERROR}), 32'b010);
        check_val("t1_nowr",   32'(wr_cnt), 32'd2);

        // 2: 18 words crossing into the high bank
        $display("test2 eighteen-word frame");
        clear_model();
        fill_random(18);
        send_frame(18, 8'h00);
        idle(2);
        check_val("t2_flags", 32'({CPU_HOLD, DONE, ERROR}), 32'b010);
        check_val("t2_wrs",   32'(wr_cnt), 32'd18);
        for (int i = 0; i < 18; i++) begin
            if (i < wlog.size())
                check_val("t2_order", 32'(wlog[i]), (i < 16) ? 32'(i) : 32'(16 + (i - 16)));
        end
        check_image("t2_mem", 18);

        // 3: illegal counts 0 and 33
        $display("test3 bad counts");
        clear_model();
        send_byte(8'hA5);
        send_byte(8'h00);
        check_val("t3a_flags", 32'({CPU_HOLD, DONE, ERROR, BYTE_READY}), 32'b0011);
        idle(3);
        send_byte(8'hA5);
        send_byte(8'h21);
        check_val("t3b_flags", 32'({CPU_HOLD, DONE, ERROR, BYTE_READY}), 32'b0011);
        idle(3);
        check_val("t3_nowr", 32'(wr_cnt), 32'd0);

        // 4: bad checksum then good frame
        $display("test4 bad checksum");
        clear_model();
        fill_random(3);
        send_frame(3, 8'hFF);
        idle(2);
        check_val("t4_flags", 32'({CPU_HOLD, DONE, ERROR}), 32'b001);
        check_val("t4_wrs",   32'(wr_cnt), 32'd3);
        check_image("t4_mem", 3);
        clear_model();
        fill_random(2);
        send_frame(2, 8'h00);
        idle(2);
        check_val("t4_recover", 32'({CPU_HOLD, DONE, ERROR}), 32'b010);

        // 5: reset after 3 of 5 words
        $display("test5 reset mid-frame");
        clear_model();
        fill_random(5);
        send_byte(8'hA5);
        send_byte(8'h05);
        for (int i = 0; i < 3; i++) begin
            send_byte(img[i][15:8]);
            send_byte(img[i][7:0]);
        end
        @(negedge CLOCK);
        #1 RESET = 1'b1;
        #1;
        check_val("t5_rst_out", 32'({BYTE_READY, WRITE_ENABLE_HIGH, WRITE_ENABLE_LOW, CPU_HOLD, DONE, ERROR}), 32'b100000);
        check_val("t5_rst_bus", 32'({IMEM_INPUT, WRITE_SELECT}), 32'd0);
        @(negedge CLOCK);
        RESET = 1'b0;
        idle(2);
        check_val("t5_wrs", 32'(wr_cnt), 32'd3);
        check_image("t5_mem", 3);
        clear_model();
        fill_random(2);
        send_frame(2, 8'h00);
        idle(2);
        check_val("t5_reload", 32'({CPU_HOLD, DONE, ERROR}), 32'b010);
        check_image("t5_mem2", 2);

        // 6: valid held high, full depth; then random gaps
        $display("test6 back-to-back full depth");
        clear_model();
        fill_random(32);
        c0 = cyc;
        r0 = rdy_low;
        send_frame(32, 8'h00);
        check_val("t6_cycles", 32'(cyc - c0), 32'd99);
        idle(2);
        check_val("t6_rdylow", 32'(rdy_low - r0), 32'd32);
        check_val("t6_flags",  32'({CPU_HOLD, DONE, ERROR}), 32'b010);
        check_image("t6_mem", 32);
        $display("test6 gapped stream");
        clear_model();
        fill_random(4);
        gap_max = 3;
        send_frame(4, 8'h00);
        gap_max = 0;
        idle(2);
        check_val("t6g_flags", 32'({CPU_HOLD, DONE, ERROR}), 32'b010);
        check_image("t6g_mem", 4);
        check_val("we_ready_rules", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
